// File: rtl/popcount_accumulator.sv
// Accumulates 4-bit partial popcounts over a variable-length vector and
// presents the total, beat count, flags and activation bit through a held output register.
module popcount_accumulator #(
   parameter int unsigned ACC_W  = 10,
   parameter int unsigned BEAT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        cnt_in,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   input  logic [ACC_W-1:0]  thresh,
   output logic [ACC_W-1:0]  out_sum,
   output logic [BEAT_W-1:0] out_beats,
   output logic              out_bit,
   output logic              out_sat,
   output logic              out_err,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   localparam logic [3:0]        CNT_MAX   = 4'd13;
   localparam logic [ACC_W-1:0]  ACC_MAX   = '1;
   localparam logic [BEAT_W-1:0] BEATS_MAX = '1;

   logic [1:0]        state, state_nx;
   logic [ACC_W-1:0]  acc, acc_nx;
   logic [BEAT_W-1:0] beats, beats_nx;
   logic              sat, sat_nx;
   logic              err, err_nx;

   logic              accept_c;
   logic              load_c;
   logic              err_beat_c;
   logic [3:0]        eff_c;
   logic [ACC_W:0]    sum_wide_c;
   logic              sat_beat_c;
   logic [ACC_W-1:0]  acc_upd_c;
   logic [BEAT_W-1:0] beats_upd_c;

   // Per-beat datapath: clamp illegal counts, saturating adds
   always_comb begin
      accept_c    = in_valid && in_ready;
      err_beat_c  = (cnt_in > CNT_MAX);
      eff_c       = err_beat_c ? CNT_MAX : cnt_in;
      sum_wide_c  = {1'b0, acc} + (ACC_W+1)'(eff_c);
      sat_beat_c  = sum_wide_c[ACC_W];
      acc_upd_c   = sat_beat_c ? ACC_MAX : sum_wide_c[ACC_W-1:0];
      beats_upd_c = (beats == BEATS_MAX) ? beats : beats + BEAT_W'(1);
   end

   // Next-state and accumulator update
   always_comb begin
      state_nx = state;
      acc_nx   = acc;
      beats_nx = beats;
      sat_nx   = sat;
      err_nx   = err;
      load_c   = 1'b0;
      case (state)
         IDLE, ACCUM: begin
            if (accept_c) begin
               if (in_last) begin
                  state_nx = HOLD;
                  load_c   = 1'b1;
                  acc_nx   = '0;
                  beats_nx = '0;
                  sat_nx   = 1'b0;
                  err_nx   = 1'b0;
               end else begin
                  state_nx = ACCUM;
                  acc_nx   = acc_upd_c;
                  beats_nx = beats_upd_c;
                  sat_nx   = sat | sat_beat_c;
                  err_nx   = err | err_beat_c;
               end
            end
         end
         HOLD: begin
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Accumulator, handshake flags and the held result register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         beats     <= '0;
         sat       <= 1'b0;
         err       <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_beats <= '0;
         out_bit   <= 1'b0;
         out_sat   <= 1'b0;
         out_err   <= 1'b0;
      end else begin
         acc       <= acc_nx;
         beats     <= beats_nx;
         sat       <= sat_nx;
         err       <= err_nx;
         in_ready  <= (state_nx != HOLD);
         out_valid <= (state_nx == HOLD);
         if (load_c) begin
            out_sum   <= acc_upd_c;
            out_beats <= beats_upd_c;
            out_bit   <= (acc_upd_c >= thresh);
            out_sat   <= sat | sat_beat_c;
            out_err   <= err | err_beat_c;
         end
      end
   end

endmodule

// File: tb/tb_popcount_accumulator.sv
// Directed bench for popcount_accumulator; a 6-bit-accumulator instance shares
// the stimulus so the saturation path can be reached with a short vector.
module tb_popcount_accumulator;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] cnt_in;
   logic       in_valid;
   logic       in_last;
   logic [9:0] thresh;
   logic       out_ready;

   logic       in_ready,  out_bit,  out_sat,  out_err,  out_valid;
   logic [9:0] out_sum;
   logic [7:0] out_beats;

   logic       in_ready6, out_bit6, out_sat6, out_err6, out_valid6;
   logic [5:0] out_sum6;
   logic [7:0] out_beats6;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   popcount_accumulator #(.ACC_W(10), .BEAT_W(8)) dut (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .thresh(thresh), .out_sum(out_sum), .out_beats(out_beats),
      .out_bit(out_bit), .out_sat(out_sat), .out_err(out_err), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   popcount_accumulator #(.ACC_W(6), .BEAT_W(8)) dut6 (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready6), .thresh(thresh[5:0]), .out_sum(out_sum6), .out_beats(out_beats6),
      .out_bit(out_bit6), .out_sat(out_sat6), .out_err(out_err6), .out_valid(out_valid6),
      .out_ready(out_ready)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [3:0] c, input logic last);
      in_valid = 1'b1;
      cnt_in   = c;
      in_last  = last;
      step();
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; cnt_in = '0; in_valid = 1'b0; in_last = 1'b0; thresh = '0; out_ready = 1'b0;
      step(); step();
      checks++;
      if ({in_ready, out_valid, out_sum, out_beats, out_bit, out_sat, out_err} !== {1'b1, 1'b0, 10'd0, 8'd0, 3'b000}) begin
         errors++;
         $display("FAIL reset_state: rdy=%b vld=%b sum=%0d beats=%0d bit=%b sat=%b err=%b, required rdy=1 vld=0 rest 0",
                  in_ready, out_valid, out_sum, out_beats, out_bit, out_sat, out_err);
      end
      #3 rst = 1'b0;
      step();
   endtask

   task automatic test_single_beat();
      thresh = 10'd5;
      beat(4'd7, 1'b1);
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_sum, out_beats, out_bit, out_sat, out_err, in_ready} !== {1'b1, 10'd7, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL single_beat: vld=%b sum=%0d beats=%0d bit=%b sat=%b err=%b rdy=%b, required 1 7 1 1 0 0 0",
                  out_valid, out_sum, out_beats, out_bit, out_sat, out_err, in_ready);
      end
      drain();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_release: vld=%b rdy=%b, required vld=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      thresh = 10'd40;
      out_ready = 1'b1;
      beat(4'd13, 1'b0);
      beat(4'd13, 1'b0);
      beat(4'd13, 1'b0);
      beat(4'd0, 1'b1);
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_sum, out_beats, out_bit, in_ready} !== {1'b1, 10'd39, 8'd4, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL b2b_result: vld=%b sum=%0d beats=%0d bit=%b rdy=%b, required 1 39 4 0 0",
                  out_valid, out_sum, out_beats, out_bit, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 10'd39) begin
         errors++;
         $display("FAIL b2b_release: vld=%b rdy=%b sum=%0d, required vld=0 rdy=1 sum=39", out_valid, in_ready, out_sum);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_threshold();
      thresh = 10'd6;
      beat(4'd6, 1'b1);
      checks++;
      if (out_bit !== 1'b1) begin
         errors++;
         $display("FAIL thresh_equal: out_bit=%b, required 1", out_bit);
      end
      drain();
      thresh = 10'd7;
      beat(4'd6, 1'b1);
      checks++;
      if (out_bit !== 1'b0) begin
         errors++;
         $display("FAIL thresh_above: out_bit=%b, required 0", out_bit);
      end
      drain();
   endtask

   task automatic test_backpressure();
      thresh = 10'd0;
      beat(4'd9, 1'b1);
      cnt_in = 4'd5;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if ({in_ready, out_valid, out_sum, out_beats} !== {1'b0, 1'b1, 10'd9, 8'd1}) begin
            errors++;
            $display("FAIL backpressure_hold[%0d]: rdy=%b vld=%b sum=%0d beats=%0d, required 0 1 9 1",
                     i, in_ready, out_valid, out_sum, out_beats);
         end
      end
      drain();
      checks++;
      if (out_valid !== 1'b0 || out_sum !== 10'd9) begin
         errors++;
         $display("FAIL backpressure_release: vld=%b sum=%0d, required vld=0 sum=9", out_valid, out_sum);
      end
      beat(4'd3, 1'b1);
      checks++;
      if (out_sum !== 10'd3 || out_beats !== 8'd1) begin
         errors++;
         $display("FAIL backpressure_next: sum=%0d beats=%0d, required 3 1", out_sum, out_beats);
      end
      drain();
   endtask

   task automatic test_saturation();
      thresh = 10'd0;
      for (int i = 0; i < 5; i++) beat(4'd13, 1'b0);
      beat(4'd13, 1'b1);
      in_valid = 1'b0;
      checks++;
      if ({out_sum6, out_sat6, out_beats6} !== {6'd63, 1'b1, 8'd6}) begin
         errors++;
         $display("FAIL sat6_result: sum=%0d sat=%b beats=%0d, required 63 1 6", out_sum6, out_sat6, out_beats6);
      end
      checks++;
      if (out_sum !== 10'd78 || out_sat !== 1'b0) begin
         errors++;
         $display("FAIL sat10_result: sum=%0d sat=%b, required 78 0", out_sum, out_sat);
      end
      drain();
      beat(4'd2, 1'b1);
      checks++;
      if (out_sum6 !== 6'd2 || out_sat6 !== 1'b0) begin
         errors++;
         $display("FAIL sat6_next: sum=%0d sat=%b, required 2 0", out_sum6, out_sat6);
      end
      drain();
   endtask

   task automatic test_illegal();
      thresh = 10'd14;
      beat(4'd15, 1'b0);
      beat(4'd1, 1'b1);
      checks++;
      if ({out_sum, out_err, out_beats, out_bit} !== {10'd14, 1'b1, 8'd2, 1'b1}) begin
         errors++;
         $display("FAIL illegal_result: sum=%0d err=%b beats=%0d bit=%b, required 14 1 2 1",
                  out_sum, out_err, out_beats, out_bit);
      end
      drain();
      beat(4'd1, 1'b1);
      checks++;
      if (out_err !== 1'b0 || out_sum !== 10'd1) begin
         errors++;
         $display("FAIL illegal_next: err=%b sum=%0d, required 0 1", out_err, out_sum);
      end
      drain();
   endtask

   task automatic test_reset_midvector();
      thresh = 10'd0;
      beat(4'd10, 1'b0);
      beat(4'd10, 1'b0);
      beat(4'd10, 1'b0);
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL midvector_state: rdy=%b vld=%b, required 1 0", in_ready, out_valid);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({in_ready, out_valid, out_sum, out_beats, out_bit, out_sat, out_err} !== {1'b1, 1'b0, 10'd0, 8'd0, 3'b000}) begin
         errors++;
         $display("FAIL midvector_reset: rdy=%b vld=%b sum=%0d beats=%0d bit=%b sat=%b err=%b, required 1 0 0 0 0 0 0",
                  in_ready, out_valid, out_sum, out_beats, out_bit, out_sat, out_err);
      end
      step();
      rst = 1'b0;
      step();
      beat(4'd4, 1'b1);
      checks++;
      if (out_sum !== 10'd4 || out_beats !== 8'd1 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL after_reset: sum=%0d beats=%0d vld=%b, required 4 1 1", out_sum, out_beats, out_valid);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_back_to_back();
      test_threshold();
      test_backpressure();
      test_saturation();
      test_illegal();
      test_reset_midvector();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/popcount_accumulator.md
# popcount_accumulator

Sequential stage directly downstream of the 13-to-4 compressor adder. It accumulates the 4-bit partial popcounts (0..13) that the compressor produces for each 13-bit slice of an XNOR product vector, one slice per beat, over a variable-length vector. At the end of the vector it emits the total popcount, the beat count, saturation/error flags and a binarised activation bit through a valid/ready output register.

## Interface
- ACC_W, 10, accumulator and threshold width; sum saturates at 2^ACC_W-1
- BEAT_W, 8, beat counter width; count saturates at 2^BEAT_W-1
- clk  input  1  clock; all state on rising edge
- rst  input  1  reset, asynchronous and active-high
- cnt_in  input  4  partial popcount from the compressor; legal range 0..13
- in_valid  input  1  cnt_in is valid this cycle
- in_last  input  1  qualifies the final beat of the vector
- in_ready  output  1  block accepts a beat this cycle
- thresh  input  ACC_W  activation threshold; sampled on the last-beat accept
- out_sum  output  ACC_W  total popcount of the vector
- out_beats  output  BEAT_W  number of beats accepted for the vector
- out_bit  output  1  1 when out_sum >= sampled thresh
- out_sat  output  1  accumulator saturated during the vector
- out_err  output  1  at least one beat had cnt_in > 13
- out_valid  output  1  output register holds a result
- out_ready  input  1  downstream consumes the result
- Clocking and reset: one clock, clk; reset rst is asynchronous and active-high.

## Operation
- States: IDLE (no beats yet), ACCUM (at least one beat accepted, no last beat yet), HOLD (result waiting for the consumer).
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD. A beat is accepted when in_valid && in_ready.
- Accepted beat: the effective count is min(cnt_in, 13). If cnt_in > 13, the sticky err bit is set. Then acc <= acc + effective count, saturating at 2^ACC_W-1, and the sticky sat bit is set on saturation. beats <= beats + 1, saturating.
- IDLE to ACCUM on an accepted beat with in_last = 0.
- IDLE or ACCUM to HOLD on an accepted beat with in_last = 1. The output register loads the final sum (including this beat), the final beats count, the final flags, and out_bit = (final sum >= thresh), unsigned compare.
- The internal acc, beats, sat and err clear on entry to HOLD, so the next vector starts from 0.
- HOLD to IDLE when out_ready = 1. out_valid deasserts next cycle. out_sum, out_beats, out_bit, out_sat and out_err keep their last values until the next load.
- in_valid while in_ready = 0 is not a transfer. The upstream holds the data and the block takes no action.
- A vector of one beat (in_last on the first beat) is legal: IDLE goes straight to HOLD.
- Reset at any time, including mid-vector or in HOLD, discards partial and held results. No result is emitted for an aborted vector.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_sum = 0, out_beats = 0, out_bit = 0, out_sat = 0, out_err = 0; state = IDLE; acc = 0, beats = 0.
- Throughput: one beat per cycle while in IDLE or ACCUM.
- Latency: out_valid rises on the clock edge that accepts the last beat. Outputs are visible in the following cycle.
- In HOLD, out_valid and all result outputs are stable until out_ready = 1 has been sampled.
- There is no same-cycle bypass. in_ready rises the cycle after the result handshake, so minimum spacing is 2 cycles between the last beat of vector N and the first beat of vector N+1.
- Output handshake completes on the edge where out_valid && out_ready.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Reset then one beat with cnt_in = 7, in_last = 1, thresh = 5 -> next cycle out_valid = 1, out_sum = 7, out_beats = 1, out_bit = 1, out_sat = 0, out_err = 0, in_ready = 0.
- Four back-to-back beats 13, 13, 13, 0 (last on the fourth), thresh = 40, out_ready = 1 -> out_sum = 39, out_beats = 4, out_bit = 0. in_ready returns high 2 cycles after the last beat.
- Backpressure: result held with out_ready = 0 for 5 cycles while in_valid = 1 -> in_ready = 0 throughout, no beats accepted, outputs unchanged. Then out_ready = 1 -> out_valid = 0 next cycle.
- Saturation with ACC_W = 6: six beats of 13 -> out_sum = 63, out_sat = 1. Next vector of one beat with cnt_in = 2 -> out_sum = 2, out_sat = 0.
- Illegal input: beats 15, 1 (last) -> out_sum = 14, out_err = 1.
- Assert rst after 3 accepted beats of 10 -> all outputs return to reset values. Next vector with one beat of 4 -> out_sum = 4, out_beats = 1.
